// File: rtl/seg7_pkg.sv
// Shared constants, types and slot decode helpers for the seven-segment scan controller.
package seg7_pkg;

  localparam logic [2:0] CA_LEFT  = 3'b011;
  localparam logic [2:0] CA_MID   = 3'b101;
  localparam logic [2:0] CA_RIGHT = 3'b110;
  localparam logic [2:0] CA_OFF   = 3'b111;

  typedef logic [11:0] disp_t;

  function automatic logic [2:0] slot_ca(input logic [1:0] slot);
    logic [2:0] pat;
    case (slot)
      2'd0:    pat = CA_LEFT;
      2'd1:    pat = CA_MID;
      2'd2:    pat = CA_RIGHT;
      default: pat = CA_OFF;
    endcase
    return pat;
  endfunction

  function automatic logic [3:0] slot_nibble(input disp_t d, input logic [1:0] slot);
    logic [3:0] nib;
    case (slot)
      2'd0:    nib = d[11:8];
      2'd1:    nib = d[7:4];
      2'd2:    nib = d[3:0];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/seg7_val_latch.sv
// Shadow register with valid/ready intake; the pending value is released at a frame boundary.
module seg7_val_latch
  import seg7_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  disp_t val_in,
  input  logic  val_valid,
  output logic  val_ready,
  input  logic  frame_load,
  output disp_t shadow,
  output logic  pending
);

  assign val_ready = !pending;

  // Accept only when empty, so an accept never collides with a boundary clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= 12'h000;
      pending <= 1'b0;
    end else if (val_valid && val_ready) begin
      shadow  <= val_in;
      pending <= 1'b1;
    end else if (frame_load) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Three-digit common-anode scan scheduler with anti-ghost blanking, 16-level PWM
// and frame-aligned value updates.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DWELL_CYCLES = 8192,
  parameter int BLANK_CYCLES = 256
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic [11:0] val_in,
  input  logic        val_valid,
  output logic        val_ready,
  input  logic [3:0]  brightness,
  output logic [2:0]  ca,
  output logic [3:0]  digit,
  output logic        frame_start
);

  localparam int CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_START = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       slot;
  disp_t            disp;
  disp_t            shadow;
  logic             pending;
  logic [3:0]       bright_q;
  logic             boundary;
  logic             lit;

  assign boundary = (slot == 2'd2) && (cnt == CNT_MAX);
  assign lit      = (cnt >= BLANK_START) && (cnt[3:0] < bright_q);

  seg7_val_latch u_val_latch (
    .clk        (clk_25mhz),
    .reset      (reset),
    .val_in     (val_in),
    .val_valid  (val_valid),
    .val_ready  (val_ready),
    .frame_load (boundary),
    .shadow     (shadow),
    .pending    (pending)
  );

  // Dwell/slot counters, frame-boundary loads, and outputs registered from the current state.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      slot        <= 2'd0;
      disp        <= 12'h000;
      bright_q    <= 4'd15;
      ca          <= CA_OFF;
      digit       <= 4'h0;
      frame_start <= 1'b0;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt  <= '0;
        slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (boundary) begin
        bright_q <= brightness;
        if (pending) begin
          disp <= shadow;
        end
      end
      ca          <= lit ? slot_ca(slot) : CA_OFF;
      digit       <= slot_nibble(disp, slot);
      frame_start <= boundary;
    end
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Scan scheduler for the 3-digit common-anode seven-segment display. Time-multiplexes the three digit anodes, adds an anti-ghosting blank interval, and applies 16-level PWM brightness in each digit slot. Takes a 12-bit display value through a valid/ready handshake and applies it only at frame boundaries, so no frame mixes old and new digits. Sits between the value source and the hex-to-segment decoder and takes the place of the free-running digit scanner.

## Interface

Parameters:
- DWELL_CYCLES, 8192: clock cycles per digit slot (≈1017 Hz frame at 25 MHz). Multiple of 16, ≥ 32.
- BLANK_CYCLES, 256: cycles at the start of each slot with all anodes off. Multiple of 16, < DWELL_CYCLES.

Ports:
- clk_25mhz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- val_in  in  12  display value; [11:8] left digit, [7:4] middle, [3:0] right
- val_valid  in  1  val_in offered
- val_ready  out  1  shadow register empty, offer accepted this cycle if val_valid
- brightness  in  4  PWM level, 0 = dark, 15 = 15/16 duty
- ca  out  3  anode enables, active-low, one-cold (011 left, 101 middle, 110 right, 111 off)
- digit  out  4  nibble for the current slot, to the hex decoder
- frame_start  out  1  one-cycle pulse on the first cycle of slot 0

## Operation

- State: slot counter `slot` (0,1,2), dwell counter `cnt` (clog2(DWELL_CYCLES) bits), display register `disp[11:0]`, shadow register `shadow[11:0]`, flag `pending`, latched brightness `bright_q[3:0]`.
- `cnt` increments each cycle. At DWELL_CYCLES−1 it wraps to 0 and `slot` advances 0→1→2→0.
- Frame boundary is the edge where `slot`==2 and `cnt`==DWELL_CYCLES−1. At that edge:
  - `disp`<=`shadow` and `pending`<=0 if `pending`
  - `bright_q`<=brightness
- Handshake:
  - val_ready = !pending (combinational).
  - When val_valid && val_ready: `shadow`<=val_in and `pending`<=1.
  - val_valid with val_ready low is ignored. The source holds the value.
  - Accept and frame boundary in the same cycle: the value goes to `shadow`. It is not displayed until the following boundary.
- Lit condition for a state: `cnt` ≥ BLANK_CYCLES && `cnt[3:0]` < `bright_q`.
- Registered outputs:
  - ca = slot pattern if lit, else 111.
  - digit = `disp` nibble for `slot`, regardless of lit.
  - frame_start = 1 when next state is `slot`==0 and `cnt`==0.
- Per-slot lit cycles = (DWELL_CYCLES−BLANK_CYCLES)/16 × `bright_q`.

## Timing

- Reset values:
  - `cnt`=0, `slot`=0, `disp`=0, `shadow`=0, `pending`=0, `bright_q`=15
  - ca=111, digit=0, frame_start=0, val_ready=1
- Reset assertion forces ca=111 immediately. There is no partial-slot completion. A pending value is discarded.
- ca, digit and frame_start lag state by one cycle. The first slot after reset shows `disp`=0 (digit 0).
- Value latency: acceptance → display ≤ 3×DWELL_CYCLES+1 cycles, and always at a frame_start.
- val_ready falls the cycle after acceptance. It rises the cycle after the next frame boundary.
- A brightness change mid-frame takes effect from the next frame_start.
- Frame period is exactly 3×DWELL_CYCLES. frame_start pulses once per period.

## Structure

- Package `seg7_pkg`:
  - constants CA_LEFT=3'b011, CA_MID=3'b101, CA_RIGHT=3'b110, CA_OFF=3'b111
  - typedef for the 12-bit display value
- Sub-module `seg7_val_latch`: shadow register, pending flag and handshake, with frame-boundary load input.
- Scan and PWM logic stay in the top of the block.

## Test plan

Bench parameters: DWELL_CYCLES=64, BLANK_CYCLES=16.

- **Reset:** assert reset → ca=111, digit=0, val_ready=1, frame_start=0. Release → first 17 cycles ca=111; frame_start first pulses at cycle 192.
- **Scan order:** load 0xABC, brightness=15. Next frame:
  - ca=011/digit=A, then 101/digit=B, then 110/digit=C.
  - Exactly 45 lit cycles per slot.
  - Frame period 192 cycles.
- **Handshake:** val_in=0x123 valid for one cycle mid-frame.
  - val_ready low the next cycle.
  - Old digits hold until frame_start, then 1/2/3 shown.
  - val_ready returns 1 after the boundary.
- **Backpressure:** with 0x123 pending, offer 0x456 → not accepted while val_ready=0. Accepted after the boundary, displayed one frame later.
- **Brightness:**
  - brightness=0 → ca stays 111 for a full frame.
  - Change to 8 mid-frame → unchanged until frame_start, then 24 lit cycles per slot.
- **Reset mid-slot:** reset while ca=101 with a value pending → ca=111 immediately, pending dropped. After release digit=0 and val_ready=1.
